// File: rtl/track_uturn_pkg.sv
// Shared types for the line-follow / U-turn motion block: FSM states,
// wheel indices, direction levels and the sensor-bar steering table.
package track_uturn_pkg;

  localparam int   NUM_WHEELS = 2;
  localparam int   WHL_L      = 0;
  localparam int   WHL_R      = 1;
  localparam logic DIR_FWD    = 1'b1;
  localparam logic DIR_REV    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TRACK, ST_EOT_HOLD, ST_SPIN_OUT, ST_SPIN_IN, ST_DONE
  } state_t;

  typedef struct packed {
    logic hit;     // pattern recognised; otherwise previous duties are kept
    logic slow_l;
    logic slow_r;
  } steer_t;

  // bit3 is the leftmost sensor: line drifting left slows the left wheel
  function automatic steer_t steer_lookup(input logic [3:0] l);
    steer_t s;
    s = '0;
    case (l)
      4'b0110, 4'b1111:          s = '{hit: 1'b1, slow_l: 1'b0, slow_r: 1'b0};
      4'b0100, 4'b1100, 4'b1000: s = '{hit: 1'b1, slow_l: 1'b1, slow_r: 1'b0};
      4'b0010, 4'b0011, 4'b0001: s = '{hit: 1'b1, slow_l: 1'b0, slow_r: 1'b1};
      default:                   s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/track_uturn_pwm_channel.sv
// One wheel: duty latched on request, PWM compare against the shared period
// counter, and a direction bit that may only move while the output is low.
module track_uturn_pwm_channel
  import track_uturn_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty,
  input  logic          load,
  input  logic          run,
  input  logic          dir_tgt,
  output logic          pwm,
  output logic          dir
);

  logic [CW-1:0] duty_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q <= '0;
      pwm    <= 1'b0;
      dir    <= DIR_FWD;
    end else begin
      if (load) duty_q <= duty;
      pwm <= run && (cnt < duty_q);
      if (!pwm) dir <= dir_tgt;
    end
  end

endmodule

// File: rtl/track_uturn.sv
// Motion responder: follows the line on en_tracking, spins in place on
// en_uturn, and reports end_of_track / uturn_finished to the core FSM.
module track_uturn
  import track_uturn_pkg::*;
#(
  parameter int PWM_PERIOD       = 2500,
  parameter int DUTY_FAST        = 2000,
  parameter int DUTY_SLOW        = 800,
  parameter int DUTY_SPIN        = 1500,
  parameter int EOT_CYCLES       = 5_000_000,
  parameter int UTURN_MIN_CYCLES = 25_000_000,
  parameter int UTURN_MAX_CYCLES = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tracking,
  input  logic       en_uturn,
  input  logic [3:0] line,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       end_of_track,
  output logic       uturn_finished
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int LW = $clog2(EOT_CYCLES + 1);
  localparam int SW = $clog2(UTURN_MAX_CYCLES + 1);
  localparam logic [CW-1:0] PMAX  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DFAST = CW'(DUTY_FAST);
  localparam logic [CW-1:0] DSLOW = CW'(DUTY_SLOW);
  localparam logic [CW-1:0] DSPIN = CW'(DUTY_SPIN);
  localparam logic [LW-1:0] LMAX  = LW'(EOT_CYCLES);
  localparam logic [SW-1:0] SMIN  = SW'(UTURN_MIN_CYCLES);
  localparam logic [SW-1:0] SMAX  = SW'(UTURN_MAX_CYCLES);

  logic [3:0]                     line_s1, line_s2;
  state_t                         state, nxt;
  logic [LW-1:0]                  lost_cnt, lost_inc;
  logic [SW-1:0]                  spin_cnt, spin_inc;
  logic [CW-1:0]                  cnt;
  logic [NUM_WHEELS-1:0][CW-1:0]  steer, duty_tgt;
  logic [NUM_WHEELS-1:0]          dir_tgt, pwm, dir;
  logic                           spinning, lost, run, wrap, load;
  steer_t                         st;

  always_comb begin
    spinning = (state == ST_SPIN_OUT) || (state == ST_SPIN_IN);
    lost     = (line_s2 == 4'b0000);
    lost_inc = (lost_cnt == LMAX) ? lost_cnt : lost_cnt + LW'(1);
    spin_inc = (spin_cnt == SMAX) ? spin_cnt : spin_cnt + SW'(1);
    st       = steer_lookup(line_s2);
    nxt      = state;
    // DONE is not overridden: it holds until the core releases en_uturn
    if (en_uturn && !spinning && state != ST_DONE) nxt = ST_SPIN_OUT;
    else begin
      case (state)
        ST_IDLE:     if (en_tracking) nxt = ST_TRACK;
        ST_TRACK:    if (!en_tracking) nxt = ST_IDLE;
                     else if (lost && lost_inc == LMAX) nxt = ST_EOT_HOLD;
        ST_EOT_HOLD: if (!en_tracking) nxt = ST_IDLE;
        ST_SPIN_OUT: if (!en_uturn) nxt = ST_IDLE;
                     else if (spin_inc == SMIN) nxt = ST_SPIN_IN;
        ST_SPIN_IN:  if (!en_uturn) nxt = ST_IDLE;
                     else if (line_s2[2:1] != 2'b00 || spin_inc == SMAX) nxt = ST_DONE;
        ST_DONE:     if (!en_uturn) nxt = en_tracking ? ST_TRACK : ST_IDLE;
        default:     nxt = ST_IDLE;
      endcase
    end
  end

  // spin_cnt is 0 only in the first SPIN_OUT cycle: that is the forced stop
  always_comb begin
    run            = (state == ST_TRACK) || (spinning && spin_cnt != '0);
    wrap           = (cnt == PMAX);
    load           = wrap || (state != ST_TRACK);
    dir_tgt[WHL_L] = (run && spinning) ? DIR_REV : DIR_FWD;
    dir_tgt[WHL_R] = DIR_FWD;
    if (state == ST_TRACK) duty_tgt = steer;
    else if (spinning)     duty_tgt = {NUM_WHEELS{DSPIN}};
    else                   duty_tgt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_s1        <= '0;
      line_s2        <= '0;
      state          <= ST_IDLE;
      lost_cnt       <= '0;
      spin_cnt       <= '0;
      cnt            <= '0;
      steer          <= '0;
      end_of_track   <= 1'b0;
      uturn_finished <= 1'b0;
    end else begin
      line_s1  <= line;
      line_s2  <= line_s1;
      state    <= nxt;
      cnt      <= wrap ? '0 : cnt + CW'(1);
      lost_cnt <= (state == ST_TRACK && lost) ? lost_inc : '0;
      if (nxt == ST_SPIN_OUT && state != ST_SPIN_OUT) spin_cnt <= '0;
      else if (spinning)                              spin_cnt <= spin_inc;
      if (state == ST_TRACK && st.hit) begin
        steer[WHL_L] <= st.slow_l ? DSLOW : DFAST;
        steer[WHL_R] <= st.slow_r ? DSLOW : DFAST;
      end
      end_of_track   <= (nxt == ST_EOT_HOLD);
      uturn_finished <= (nxt == ST_DONE) && (state != ST_DONE);
    end
  end

  for (genvar w = 0; w < NUM_WHEELS; w++) begin : g_ch
    track_uturn_pwm_channel #(.CW(CW)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .duty    (duty_tgt[w]),
      .load    (load),
      .run     (run),
      .dir_tgt (dir_tgt[w]),
      .pwm     (pwm[w]),
      .dir     (dir[w])
    );
  end

  assign pwm_l = pwm[WHL_L];
  assign pwm_r = pwm[WHL_R];
  assign dir_l = dir[WHL_L];
  assign dir_r = dir[WHL_R];

endmodule

// File: tb/tb_track_uturn.sv
// Bench for track_uturn: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the motion rules.
module tb_track_uturn;

  localparam int P = 10, FAST = 8, SLOW = 3, SPIN = 5, EOT = 20, UMIN = 30, UMAX = 100;
  localparam int M_IDLE = 0, M_TRACK = 1, M_EOT = 2, M_SOUT = 3, M_SIN = 4, M_DONE = 5;

  logic       clk = 1'b0, rst = 1'b0, en_t = 1'b0, en_u = 1'b0;
  logic [3:0] line = 4'b0000;
  logic       pwm_l, pwm_r, dir_l, dir_r, end_of_track, uturn_finished;

  track_uturn #(
    .PWM_PERIOD(P), .DUTY_FAST(FAST), .DUTY_SLOW(SLOW), .DUTY_SPIN(SPIN),
    .EOT_CYCLES(EOT), .UTURN_MIN_CYCLES(UMIN), .UTURN_MAX_CYCLES(UMAX)
  ) dut (
    .clk(clk), .rst(rst), .en_tracking(en_t), .en_uturn(en_u), .line(line),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .end_of_track(end_of_track), .uturn_finished(uturn_finished)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, fin_cnt = 0;
  bit chk_on = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
  endtask

  // ---- behavioural model: ages and run lengths, phase from elapsed cycles
  int         ms, lost, age, k, ns, phase, tgt;
  int         dq[2], sd[2];
  bit         e_pwm[2], e_dir[2], newp[2];
  bit         e_eot, e_fin, spin_now, run_now;
  logic [3:0] h1, h2, syn;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms = M_IDLE; lost = 0; age = 0; k = 0; h1 = 0; h2 = 0;
      dq = '{0, 0}; sd = '{0, 0}; e_pwm = '{0, 0}; e_dir = '{1, 1};
      e_eot = 0; e_fin = 0;
    end else begin
      syn      = h2;
      spin_now = (ms == M_SOUT || ms == M_SIN);
      ns       = ms;
      if (en_u && !spin_now && ms != M_DONE) ns = M_SOUT;
      else case (ms)
        M_IDLE:  if (en_t) ns = M_TRACK;
        M_TRACK: if (!en_t) ns = M_IDLE; else if (syn == 0 && lost + 1 >= EOT) ns = M_EOT;
        M_EOT:   if (!en_t) ns = M_IDLE;
        M_SOUT:  if (!en_u) ns = M_IDLE; else if (age + 1 >= UMIN) ns = M_SIN;
        M_SIN:   if (!en_u) ns = M_IDLE;
                 else if (syn[2:1] != 0 || age + 1 >= UMAX) ns = M_DONE;
        M_DONE:  if (!en_u) ns = en_t ? M_TRACK : M_IDLE;
        default: ns = M_IDLE;
      endcase
      run_now = (ms == M_TRACK) || (spin_now && age > 0);
      phase   = k % P;
      for (int w = 0; w < 2; w++) begin
        newp[w] = run_now && (phase < dq[w]);
        if (!e_pwm[w]) e_dir[w] = (w == 0 && spin_now && age > 0) ? 1'b0 : 1'b1;
        tgt = (ms == M_TRACK) ? sd[w] : spin_now ? SPIN : 0;
        if (ms != M_TRACK || phase == P - 1) dq[w] = tgt;
        e_pwm[w] = newp[w];
      end
      if (ms == M_TRACK) begin
        if (syn == 4'b0110 || syn == 4'b1111) sd = '{FAST, FAST};
        else if (syn == 4'b0100 || syn == 4'b1100 || syn == 4'b1000) sd = '{SLOW, FAST};
        else if (syn == 4'b0010 || syn == 4'b0011 || syn == 4'b0001) sd = '{FAST, SLOW};
      end
      lost = (ms == M_TRACK && syn == 0) ? ((lost + 1 > EOT) ? EOT : lost + 1) : 0;
      if (ns == M_SOUT && ms != M_SOUT) age = 0;
      else if (spin_now) age = (age + 1 > UMAX) ? UMAX : age + 1;
      e_eot = (ns == M_EOT);
      e_fin = (ns == M_DONE) && (ms != M_DONE);
      h2 = h1; h1 = line; k++; ms = ns;
    end
  end

  always @(negedge clk) begin
    if (uturn_finished) fin_cnt++;
    if (rst && chk_on) begin
      chk("pwm_l", pwm_l, e_pwm[0]);
      chk("pwm_r", pwm_r, e_pwm[1]);
      chk("dir_l", dir_l, e_dir[0]);
      chk("dir_r", dir_r, e_dir[1]);
      chk("end_of_track", end_of_track, e_eot);
      chk("uturn_finished", uturn_finished, e_fin);
    end
  end

  task automatic drive(input logic t, input logic u, input logic [3:0] l, input int n);
    en_t = t; en_u = u; line = l;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pwm_l"}, pwm_l, 0);
    chk({tag, "_pwm_r"}, pwm_r, 0);
    chk({tag, "_dir_l"}, dir_l, 1);
    chk({tag, "_dir_r"}, dir_r, 1);
    chk({tag, "_eot"}, end_of_track, 0);
    chk({tag, "_fin"}, uturn_finished, 0);
  endtask

  task automatic duty_window(input string tag, input int exp_l, input int exp_r);
    int hl, hr;
    hl = 0; hr = 0;
    repeat (P) begin
      @(negedge clk);
      hl += int'(pwm_l); hr += int'(pwm_r);
    end
    chk({tag, "_l"}, hl, exp_l);
    chk({tag, "_r"}, hr, exp_r);
  endtask

  logic [3:0] pats [8] = '{4'b0000, 4'b0000, 4'b0110, 4'b1000,
                           4'b1100, 4'b0001, 4'b0011, 4'b1001};
  int f0;

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b1; chk_on = 1'b1;

    // straight, then line under the left sensor
    drive(1, 0, 4'b0110, 40);
    duty_window("duty_ff", FAST, FAST);
    drive(1, 0, 4'b1000, 30);
    duty_window("duty_sf", SLOW, FAST);

    // lost run broken once, then a full run declares end of track
    drive(1, 0, 4'b0000, 19);
    drive(1, 0, 4'b0110, 1);
    drive(1, 0, 4'b0000, 19);
    chk("eot_early", end_of_track, 0);
    drive(1, 0, 4'b0000, 6);
    chk("eot_set", end_of_track, 1);
    chk("eot_pwm_l", pwm_l, 0);
    chk("eot_pwm_r", pwm_r, 0);

    // U-turn from EOT_HOLD: early line ignored, later line finishes
    f0 = fin_cnt;
    drive(1, 1, 4'b0000, 10);
    chk("spin_eot", end_of_track, 0);
    chk("spin_dir_l", dir_l, 0);
    drive(1, 1, 4'b0110, 3);
    drive(1, 1, 4'b0000, 27);
    chk("spin_no_early_fin", fin_cnt - f0, 0);
    drive(1, 1, 4'b0110, 10);
    chk("fin_by_line", fin_cnt - f0, 1);
    chk("done_pwm_l", pwm_l, 0);
    drive(1, 0, 4'b0110, 30);
    chk("resume_dir_l", dir_l, 1);

    // timeout with no line
    f0 = fin_cnt;
    drive(1, 1, 4'b0000, 95);
    chk("timeout_early", fin_cnt - f0, 0);
    drive(1, 1, 4'b0000, 20);
    chk("fin_by_timeout", fin_cnt - f0, 1);
    chk("done_hold_pwm", pwm_r, 0);
    drive(0, 0, 4'b0000, 10);

    // both enables together, U-turn dropped mid-spin
    f0 = fin_cnt;
    drive(1, 1, 4'b0110, 15);
    chk("both_spin_dir_l", dir_l, 0);
    drive(0, 0, 4'b0110, 3);
    chk("drop_pwm_l", pwm_l, 0);
    chk("drop_pwm_r", pwm_r, 0);
    chk("drop_no_fin", fin_cnt - f0, 0);

    // asynchronous reset mid-TRACK
    drive(1, 0, 4'b0110, 25);
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) en_t = ~en_t;
      if ($urandom_range(299) == 0) en_u = ~en_u;
      if ($urandom_range(9) == 0) line = pats[$urandom_range(7)];
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
